care_scheduler: RTL and testbench

Sequences all updates to the pet statistics datapath. It collects sticky button requests (feed, play, heal, clean, sleep, social) and arbitrates them round-robin. It also inserts periodic random decay operations when the player is idle. It issues exactly one operation at a time to the stats update stage over a valid/ready handshake, with a cooldown after every player action.

---
 rtl/care_pkg.sv | 27 ++
 rtl/care_scheduler_rr_arbiter.sv | 30 +++
 rtl/care_scheduler.sv | 166 ++++++++++++++++
 tb/tb_care_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/care_pkg.sv
// Shared types and constants for the pet-care operation scheduler.
package care_pkg;

    localparam int N_ACT  = 6;
    localparam int IDX_W  = 3;
    localparam int COOL_W = 8;
    localparam int TICK_W = 18;

    localparam logic [IDX_W-1:0] ACT_FEED   = 3'd0;
    localparam logic [IDX_W-1:0] ACT_PLAY   = 3'd1;
    localparam logic [IDX_W-1:0] ACT_HEAL   = 3'd2;
    localparam logic [IDX_W-1:0] ACT_CLEAN  = 3'd3;
    localparam logic [IDX_W-1:0] ACT_SLEEP  = 3'd4;
    localparam logic [IDX_W-1:0] ACT_SOCIAL = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        COOL  = 2'd2
    } state_e;

    // Round-robin successor of an action index, wrapping after ACT_SOCIAL.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_ACT - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/care_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Latency: none (pure combinational). Backpressure: none; caller decides when to use the grant.
module rr_arbiter
    import care_pkg::*;
(
    input  logic [N_ACT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_ACT-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int k;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        k          = 0;
        // Walk from the farthest offset back to ptr so the nearest request wins.
        for (int i = N_ACT - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N_ACT;
            if (req[k]) begin
                gnt_onehot = N_ACT'(1) << k;
                gnt_idx    = IDX_W'(k);
            end
        end
        gnt_any = |req;
    end

endmodule

// File: rtl/care_scheduler.sv
// care_scheduler: latches player requests, issues them round-robin with a cooldown; idle decay ops under CARE_SCHED_DECAY_EN.
// Latency: req at edge k -> act_valid after edge k+1 when IDLE; one operation in flight at a time.
// Backpressure: act_sel/act_decay held in ISSUE until act_ready; requests keep latching into pending meanwhile.
module care_scheduler
    import care_pkg::*;
#(
    parameter int TICK_PERIOD = 1000,
    parameter int COOLDOWN    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_ACT-1:0] req,
    input  logic [7:0]       random,
    output logic             act_valid,
    input  logic             act_ready,
    output logic [IDX_W-1:0] act_sel,
    output logic             act_decay,
    output logic [N_ACT-1:0] pending,
    output logic             busy
);

    state_e              state_q, state_d;
    logic [N_ACT-1:0]    pend_q, pend_d;
    logic [N_ACT-1:0]    gnt_oh_q, gnt_oh_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                decay_q, decay_d;
    logic [COOL_W-1:0]   cool_q, cool_d;

    logic [N_ACT-1:0]    arb_onehot;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                issue_hs;
    logic [N_ACT-1:0]    clr_mask;
    logic                decay_go;
    logic [IDX_W-1:0]    decay_sel;

    rr_arbiter u_arb (
        .req        (pend_q),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    assign issue_hs = (state_q == ISSUE) && act_ready;

`ifdef CARE_SCHED_DECAY_EN
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              decay_pend_q, decay_pend_d;
    logic              tick_term;
    logic              unused_random_hi;

    assign unused_random_hi = ^random[7:2];
    assign tick_term        = (tick_q == TICK_W'(TICK_PERIOD - 1));
    assign decay_go         = decay_pend_q;
    assign decay_sel        = {1'b0, random[1:0]};

    always_comb begin
        tick_d       = tick_term ? '0 : tick_q + 1'b1;
        decay_pend_d = decay_pend_q;
        if (issue_hs && decay_q) begin
            decay_pend_d = 1'b0;
        end
        // A tick only counts when the player is fully idle; otherwise it is dropped.
        if (tick_term && (pend_q == '0) && (req == '0)) begin
            decay_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q       <= '0;
            decay_pend_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            decay_pend_q <= decay_pend_d;
        end
    end
`else
    localparam int unused_tick_period = TICK_PERIOD;
    logic unused_random;

    assign unused_random = ^random;
    assign decay_go      = 1'b0;
    assign decay_sel     = '0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        gnt_oh_d = gnt_oh_q;
        decay_d  = decay_q;
        cool_d   = cool_q;
        clr_mask = '0;

        if (issue_hs && !decay_q) begin
            clr_mask = gnt_oh_q;
        end
        // A request arriving in the same cycle its bit is cleared stays pending.
        pend_d = (pend_q & ~clr_mask) | req;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    sel_d    = arb_idx;
                    gnt_oh_d = arb_onehot;
                    decay_d  = 1'b0;
                    state_d  = ISSUE;
                end else if (decay_go) begin
                    sel_d    = decay_sel;
                    gnt_oh_d = '0;
                    decay_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (act_ready) begin
                    if (decay_q) begin
                        state_d = IDLE;
                    end else begin
                        rr_ptr_d = next_idx(sel_q);
                        cool_d   = COOL_W'(COOLDOWN - 1);
                        state_d  = COOL;
                    end
                end
            end
            COOL: begin
                if (cool_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            gnt_oh_q <= '0;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            decay_q  <= 1'b0;
            cool_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            gnt_oh_q <= gnt_oh_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            decay_q  <= decay_d;
            cool_q   <= cool_d;
        end
    end

    assign act_valid = (state_q == ISSUE);
    assign act_sel   = sel_q;
    assign act_decay = decay_q;
    assign pending   = pend_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_care_scheduler.sv
// Bench for care_scheduler: u_a (no ticks in range) exercises player arbitration, u_b (TICK_PERIOD=8) the decay path.
module tb_care_scheduler;
    import care_pkg::*;

    localparam int CD   = 4;
    localparam int TP_A = 200000;
    localparam int TP_B = 8;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [5:0] req_a, req_b, pend_a, pend_b;
    logic [7:0] rnd_a, rnd_b;
    logic       rdy_a, rdy_b, vld_a, vld_b, dec_a, dec_b, busy_a, busy_b;
    logic [2:0] sel_a, sel_b;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   tick_b = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    care_scheduler #(.TICK_PERIOD(TP_A), .COOLDOWN(CD)) u_a (
        .clk(clk), .reset(rst_a), .req(req_a), .random(rnd_a),
        .act_valid(vld_a), .act_ready(rdy_a), .act_sel(sel_a),
        .act_decay(dec_a), .pending(pend_a), .busy(busy_a)
    );

    care_scheduler #(.TICK_PERIOD(TP_B), .COOLDOWN(CD)) u_b (
        .clk(clk), .reset(rst_b), .req(req_b), .random(rnd_b),
        .act_valid(vld_b), .act_ready(rdy_b), .act_sel(sel_b),
        .act_decay(dec_b), .pending(pend_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Tick phase of u_b: 0 in reset, counts 0..TP_B-1 and wraps.
    always @(posedge clk) begin
        if (rst_b) tick_b <= 0;
        else       tick_b <= (tick_b == TP_B - 1) ? 0 : tick_b + 1;
    end

    // Handshake happens at the next edge; the edge number is cyc+1.
    always @(negedge clk) begin
        exp_t e;
        if (vld_a && rdy_a) begin
            if (exp_a.size() == 0) begin
                check_eq("a_unexpected_op", int'(sel_a) + (dec_a ? 8 : 0), -1);
            end else begin
                e = exp_a.pop_front();
                check_eq("a_op", int'(sel_a) + (dec_a ? 8 : 0), e.code);
                if (e.cyc >= 0) check_eq("a_op_edge", cyc + 1, e.cyc);
            end
        end
        if (vld_b && rdy_b) begin
            if (exp_b.size() == 0) begin
                check_eq("b_unexpected_op", int'(sel_b) + (dec_b ? 8 : 0), -1);
            end else begin
                e = exp_b.pop_front();
                check_eq("b_op", int'(sel_b) + (dec_b ? 8 : 0), e.code);
                if (e.cyc >= 0) check_eq("b_op_edge", cyc + 1, e.cyc);
            end
        end
    end

    task automatic push_a(input int code, input int edge_no);
        exp_a.push_back('{code, edge_no});
    endtask

    task automatic push_b(input int code, input int edge_no);
        exp_b.push_back('{code, edge_no});
    endtask

    task automatic wait_idle_a(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy_a && !vld_a && pend_a == '0) done = 1'b1;
        end
        check_eq("a_idle_reached", int'(done), 1);
    endtask

    task automatic wait_tick_b();
        bit found = 1'b0;
        for (int i = 0; i < 2 * TP_B && !found; i++) begin
            @(posedge clk);
            #1;
            if (tick_b == TP_B - 1) found = 1'b1;
        end
        check_eq("b_tick_found", int'(found), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rnd_tab [4];
        int base, bcnt, vcnt;
        rnd_tab = '{8'h02, 8'h02, 8'hFD, 8'h07};

        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0;   req_b = '0;
        rnd_a = 8'h00; rnd_b = 8'h02;
        rdy_a = 1'b1; rdy_b = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_vld",  int'(vld_a),  0);
        check_eq("rst_a_busy", int'(busy_a), 0);
        check_eq("rst_a_pend", int'(pend_a), 0);
        check_eq("rst_a_sel",  int'(sel_a),  0);
        check_eq("rst_a_dec",  int'(dec_a),  0);
        check_eq("rst_b_vld",  int'(vld_b),  0);
        check_eq("rst_b_busy", int'(busy_b), 0);
        check_eq("rst_b_pend", int'(pend_b), 0);
        @(posedge clk); #1;
        rst_a = 1'b0;

        // Three requests in one cycle from rr_ptr 0: feed, heal, social, COOLDOWN+1 dead cycles apart.
        @(posedge clk); #1;
        req_a = 6'b100101;
        base  = cyc;
        push_a(int'(ACT_FEED),   base + 3);
        push_a(int'(ACT_HEAL),   base + 3 + (CD + 2));
        push_a(int'(ACT_SOCIAL), base + 3 + 2 * (CD + 2));
        @(posedge clk); #1;
        req_a = '0;
        @(negedge clk);
        check_eq("t2_pending_latched", int'(pend_a), 6'b100101);
        wait_idle_a(60);

        // Single feed request: valid two edges later, busy for 1+COOLDOWN cycles.
        @(posedge clk); #1;
        req_a = 6'b000001;
        base  = cyc;
        push_a(int'(ACT_FEED), base + 3);
        @(posedge clk); #1;
        req_a = '0;
        bcnt = 0; vcnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy_a) bcnt++;
            if (vld_a)  vcnt++;
        end
        check_eq("t1_busy_cycles",  bcnt, 1 + CD);
        check_eq("t1_valid_cycles", vcnt, 1);
        check_eq("t1_pending_zero", int'(pend_a), 0);

        // Stall in ISSUE with toggling requests; rr_ptr is 1 so clean is picked.
        @(posedge clk); #1;
        rdy_a = 1'b0;
        req_a = 6'b001000;
        @(posedge clk); #1;
        req_a = '0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            req_a = i[0] ? 6'b000010 : 6'b010000;
            @(negedge clk);
            check_eq("stall_vld", int'(vld_a), 1);
            check_eq("stall_sel", int'(sel_a), int'(ACT_CLEAN));
            check_eq("stall_dec", int'(dec_a), 0);
            @(posedge clk);
        end
        #1;
        req_a = '0;
        rdy_a = 1'b1;
        push_a(int'(ACT_CLEAN), cyc + 1);
        push_a(int'(ACT_SLEEP), -1);
        push_a(int'(ACT_PLAY),  -1);
        @(negedge clk);
        check_eq("stall_pending", int'(pend_a), 6'b011010);
        wait_idle_a(60);

        // Reset while an operation is presented: it is lost and rr_ptr restarts at feed.
        @(posedge clk); #1;
        rdy_a = 1'b0;
        req_a = 6'b100100;
        @(posedge clk); #1;
        req_a = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t6_vld_before_rst", int'(vld_a), 1);
        check_eq("t6_sel_before_rst", int'(sel_a), int'(ACT_HEAL));
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check_eq("t6_vld_after_rst",  int'(vld_a),  0);
        check_eq("t6_pend_after_rst", int'(pend_a), 0);
        check_eq("t6_busy_after_rst", int'(busy_a), 0);
        @(posedge clk); #1;
        rdy_a = 1'b1;
        req_a = 6'b100001;
        base  = cyc;
        push_a(int'(ACT_FEED),   base + 3);
        push_a(int'(ACT_SOCIAL), base + 3 + (CD + 2));
        @(posedge clk); #1;
        req_a = '0;
        wait_idle_a(60);

        // Decay instance.
        @(posedge clk); #1;
        rst_b = 1'b0;
`ifdef CARE_SCHED_DECAY_EN
        for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            rnd_b = rnd_tab[p];
            wait_tick_b();
            push_b(8 + int'(rnd_b[1:0]), cyc + 3);
            repeat (3) @(posedge clk);
        end
`else
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (vld_b) vcnt++;
        end
        check_eq("b_no_decay_vld", vcnt, 0);
        @(posedge clk); #1;
`endif
        // Play request on the terminal tick edge: that tick is dropped.
        rnd_b = 8'h02;
        wait_tick_b();
        req_b = 6'b000010;
        base  = cyc;
        push_b(int'(ACT_PLAY), base + 3);
`ifdef CARE_SCHED_DECAY_EN
        push_b(8 + int'(ACT_HEAL), base + 3 + TP_B);
`endif
        @(posedge clk); #1;
        req_b = '0;
        repeat (14) @(posedge clk);
        @(negedge clk);

        check_eq("a_queue_drained", exp_a.size(), 0);
        check_eq("b_queue_drained", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
